sdram_client_arbiter: RTL and testbench

- Round-robin arbiter in front of the single-port SDRAM controller; shares it between two client ports (e.g. video fetch and CPU/bus master).
- Accepts one read or write per client, issues it on the controller's level-held req/ack interface and returns a one-cycle ack (plus read data) to the granted client.
- Holds at most one outstanding transaction; a watchdog aborts if the controller never acks.

---
 rtl/sdram_client_arbiter_if.sv | 56 +++++
 rtl/sdram_client_arbiter.sv | 118 +++++++++++
 tb/tb_sdram_client_arbiter.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_client_arbiter_if.sv
// Bundle of the two client ports and the controller-side req/ack port of the SDRAM arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface sdram_client_arbiter_if #(
  parameter int unsigned ADDR_W = 22,
  parameter int unsigned DATA_W = 16
);
  logic              ic0_req;
  logic              ic0_we;
  logic [ADDR_W-1:0] ic0_addr;
  logic [DATA_W-1:0] ic0_wdata;
  logic              oc0_ack;
  logic [DATA_W-1:0] oc0_rdata;

  logic              ic1_req;
  logic              ic1_we;
  logic [ADDR_W-1:0] ic1_addr;
  logic [DATA_W-1:0] ic1_wdata;
  logic              oc1_ack;
  logic [DATA_W-1:0] oc1_rdata;

  logic              owrite_req;
  logic [ADDR_W-1:0] owrite_address;
  logic [DATA_W-1:0] owrite_data;
  logic              iwrite_ack;
  logic              oread_req;
  logic [ADDR_W-1:0] oread_address;
  logic [DATA_W-1:0] iread_data;
  logic              iread_ack;

  logic [1:0]        ogrant;
  logic              otimeout;

  modport slave (
    input  ic0_req, ic0_we, ic0_addr, ic0_wdata,
    output oc0_ack, oc0_rdata,
    input  ic1_req, ic1_we, ic1_addr, ic1_wdata,
    output oc1_ack, oc1_rdata,
    output owrite_req, owrite_address, owrite_data,
    input  iwrite_ack,
    output oread_req, oread_address,
    input  iread_data, iread_ack,
    output ogrant, otimeout
  );

  modport master (
    output ic0_req, ic0_we, ic0_addr, ic0_wdata,
    input  oc0_ack, oc0_rdata,
    output ic1_req, ic1_we, ic1_addr, ic1_wdata,
    input  oc1_ack, oc1_rdata,
    input  owrite_req, owrite_address, owrite_data,
    output iwrite_ack,
    input  oread_req, oread_address,
    output iread_data, iread_ack,
    input  ogrant, otimeout
  );
endinterface

// File: rtl/sdram_client_arbiter.sv
// Two-client round-robin arbiter in front of a level-held req/ack SDRAM controller.
// One transaction in flight at a time; a watchdog aborts a WAIT that never sees an ack.
module sdram_client_arbiter #(
  parameter int unsigned ADDR_W      = 22,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input logic                    iclk,
  input logic                    ireset_n,
  sdram_client_arbiter_if.slave  bus
);
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              last_q, last_d;  // 1 when client 1 owned the previous grant
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              timeout_q, timeout_d;
  logic              pick1;
  logic              ack_match;
  logic              busy;
  logic              resp;

  always_ff @(posedge iclk) begin
    if (!ireset_n) begin
      state_q   <= StIdle;
      grant_q   <= 2'b00;
      last_q    <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    // Client 1 wins when alone, or on a tie when client 0 was served last.
    pick1     = bus.ic1_req && (!bus.ic0_req || !last_q);
    ack_match = we_q ? bus.iwrite_ack : bus.iread_ack;

    unique case (state_q)
      StIdle: begin
        if (bus.ic0_req || bus.ic1_req) begin
          grant_d = pick1 ? 2'b10 : 2'b01;
          last_d  = pick1;
          we_d    = pick1 ? bus.ic1_we    : bus.ic0_we;
          addr_d  = pick1 ? bus.ic1_addr  : bus.ic0_addr;
          wdata_d = pick1 ? bus.ic1_wdata : bus.ic0_wdata;
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (ack_match) begin
          rdata_d = we_q ? '0 : bus.iread_data;
          state_d = StResp;
        end else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
          rdata_d   = '0;
          timeout_d = 1'b1;
          state_d   = StResp;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StResp: begin
        grant_d = 2'b00;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy = (state_q == StIssue) || (state_q == StWait);
  assign resp = (state_q == StResp);

  assign bus.owrite_req     = busy && we_q;
  assign bus.oread_req      = busy && !we_q;
  assign bus.owrite_address = addr_q;
  assign bus.oread_address  = addr_q;
  assign bus.owrite_data    = wdata_q;

  assign bus.oc0_ack   = resp && grant_q[0];
  assign bus.oc1_ack   = resp && grant_q[1];
  assign bus.oc0_rdata = (resp && grant_q[0]) ? rdata_q : '0;
  assign bus.oc1_rdata = (resp && grant_q[1]) ? rdata_q : '0;
  assign bus.ogrant    = grant_q;
  assign bus.otimeout  = timeout_q;
endmodule

// File: tb/tb_sdram_client_arbiter.sv
// Bench for sdram_client_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model (arbitration order and a reference memory).
module tb_sdram_client_arbiter;
  localparam int unsigned AW = 22;
  localparam int unsigned DW = 16;
  localparam int unsigned TO = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sdram_client_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sdram_client_arbiter #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .iclk     (clk),
    .ireset_n (rst_n),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Controller side: automatic responder when ctrl_en, otherwise manual drive from tests.
  logic          ctrl_en    = 1'b0;
  int            ctrl_lat   = 1;
  logic [DW-1:0] rd_default = '0;
  logic          c_wack = 1'b0, c_rack = 1'b0;
  logic [DW-1:0] c_rdata = '0;
  logic          m_wack = 1'b0, m_rack = 1'b0;
  logic [DW-1:0] m_rdata = '0;
  int            lat_cnt = 0;
  logic [DW-1:0] sdram [logic [AW-1:0]];

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmd_t;
  cmd_t ctrl_log[$];

  assign bus.iwrite_ack = ctrl_en ? c_wack  : m_wack;
  assign bus.iread_ack  = ctrl_en ? c_rack  : m_rack;
  assign bus.iread_data = ctrl_en ? c_rdata : m_rdata;

  // Reference model state
  bit            model_last = 1'b1;
  logic [DW-1:0] ref_mem [logic [AW-1:0]];

  initial begin : controller
    cmd_t c;
    forever begin
      @(negedge clk);
      c_wack = 1'b0;
      c_rack = 1'b0;
      if (ctrl_en && (bus.owrite_req || bus.oread_req)) begin
        if (lat_cnt >= ctrl_lat) begin
          lat_cnt = 0;
          if (bus.owrite_req) begin
            sdram[bus.owrite_address] = bus.owrite_data;
            c_wack = 1'b1;
            c.we = 1'b1; c.addr = bus.owrite_address; c.data = bus.owrite_data;
          end else begin
            c_rdata = sdram.exists(bus.oread_address) ? sdram[bus.oread_address] : rd_default;
            c_rack  = 1'b1;
            c.we = 1'b0; c.addr = bus.oread_address; c.data = c_rdata;
          end
          ctrl_log.push_back(c);
        end else begin
          lat_cnt++;
        end
      end else begin
        lat_cnt = 0;
      end
    end
  end

  task automatic clear_inputs();
    bus.ic0_req = 1'b0; bus.ic0_we = 1'b0; bus.ic0_addr = '0; bus.ic0_wdata = '0;
    bus.ic1_req = 1'b0; bus.ic1_we = 1'b0; bus.ic1_addr = '0; bus.ic1_wdata = '0;
    m_wack = 1'b0; m_rack = 1'b0; m_rdata = '0;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    ctrl_en = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n      = 1'b1;
    model_last = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    ctrl_en = 1'b0;
    clear_inputs();
    bus.ic0_req = 1'b1;
    bus.ic1_req = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.owrite_req, bus.oread_req, bus.oc0_ack, bus.oc1_ack, bus.otimeout} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {bus.owrite_req, bus.oread_req, bus.oc0_ack, bus.oc1_ack, bus.otimeout});
    end
    n_checks++;
    if (bus.ogrant !== 2'b00) begin
      n_fail++; $display("FAIL reset_grant: got %b want 00", bus.ogrant);
    end
    n_checks++;
    if ({bus.owrite_address, bus.oread_address, bus.owrite_data, bus.oc0_rdata, bus.oc1_rdata}
        !== '0) begin
      n_fail++; $display("FAIL reset_data: address/data outputs not zero");
    end
    do_reset();
    n_checks++;
    if (bus.ogrant !== 2'b00 || bus.owrite_req !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: grant %b wreq %b want 00/0", bus.ogrant, bus.owrite_req);
    end
  endtask

  task automatic test_single_write();
    int  wr_cycles;
    bit  rd_seen;
    bit  got;
    do_reset();
    ctrl_en  = 1'b1;
    ctrl_lat = 8;
    n_checks++;
    if (bus.owrite_req !== 1'b0) begin
      n_fail++; $display("FAIL wr_pre: owrite_req %b want 0", bus.owrite_req);
    end
    bus.ic0_we = 1'b1; bus.ic0_addr = 22'h012345; bus.ic0_wdata = 16'hBEEF; bus.ic0_req = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.owrite_req !== 1'b1 || bus.owrite_address !== 22'h012345 ||
        bus.owrite_data !== 16'hBEEF || bus.ogrant !== 2'b01) begin
      n_fail++;
      $display("FAIL wr_issue: req %b addr %h data %h grant %b want 1 012345 beef 01",
               bus.owrite_req, bus.owrite_address, bus.owrite_data, bus.ogrant);
    end
    wr_cycles = 1; rd_seen = 1'b0; got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (bus.oread_req) rd_seen = 1'b1;
      if (bus.oc0_ack) begin
        got = 1'b1;
        n_checks++;
        if (bus.owrite_req !== 1'b0) begin
          n_fail++; $display("FAIL wr_req_drop: owrite_req %b want 0 during ack", bus.owrite_req);
        end
        bus.ic0_req = 1'b0;
      end else if (bus.owrite_req) begin
        wr_cycles++;
      end
    end
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL wr_ack: no oc0_ack within budget"); end
    n_checks++;
    if (wr_cycles != ctrl_lat + 1) begin
      n_fail++; $display("FAIL wr_req_len: got %0d cycles want %0d", wr_cycles, ctrl_lat + 1);
    end
    n_checks++;
    if (rd_seen) begin n_fail++; $display("FAIL wr_no_read: got oread_req high want never"); end
    @(negedge clk);
    n_checks++;
    if (bus.oc0_ack !== 1'b0 || bus.ogrant !== 2'b00) begin
      n_fail++; $display("FAIL wr_pulse: ack %b grant %b want 0/00", bus.oc0_ack, bus.ogrant);
    end
    n_checks++;
    if (ctrl_log.size() == 0 || ctrl_log[$] !== cmd_t'({1'b1, 22'h012345, 16'hBEEF})) begin
      n_fail++; $display("FAIL wr_ctrl_cmd: controller did not see write 012345/beef");
    end
  endtask

  task automatic test_single_read();
    bit got;
    bit grant_bad;
    ctrl_en    = 1'b1;
    ctrl_lat   = 3;
    rd_default = 16'hA55A;
    bus.ic1_we = 1'b0; bus.ic1_addr = 22'h3FFFFF; bus.ic1_req = 1'b1;
    got = 1'b0; grant_bad = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus.oread_req && bus.ogrant !== 2'b10) grant_bad = 1'b1;
      if (bus.oc1_ack) begin
        got = 1'b1;
        n_checks++;
        if (bus.oc1_rdata !== 16'hA55A || bus.oc0_ack !== 1'b0) begin
          n_fail++;
          $display("FAIL rd_data: rdata %h c0ack %b want a55a 0", bus.oc1_rdata, bus.oc0_ack);
        end
        bus.ic1_req = 1'b0;
      end
    end
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL rd_ack: no oc1_ack within budget"); end
    n_checks++;
    if (grant_bad) begin n_fail++; $display("FAIL rd_grant: ogrant not 10 while reading"); end
    @(negedge clk);
    n_checks++;
    if (bus.oc1_ack !== 1'b0) begin n_fail++; $display("FAIL rd_pulse: ack %b want 0", bus.oc1_ack); end
  endtask

  task automatic test_contention();
    int order[$];
    int n0, n1;
    do_reset();
    ctrl_en  = 1'b1;
    ctrl_lat = 2;
    bus.ic0_we = 1'b1; bus.ic0_addr = 22'h000100; bus.ic0_wdata = 16'h1111;
    bus.ic1_we = 1'b1; bus.ic1_addr = 22'h000200; bus.ic1_wdata = 16'h2222;
    bus.ic0_req = 1'b1; bus.ic1_req = 1'b1;
    for (int i = 0; i < 300 && order.size() < 6; i++) begin
      @(negedge clk);
      if (bus.oc0_ack) order.push_back(0);
      if (bus.oc1_ack) order.push_back(1);
    end
    bus.ic0_req = 1'b0; bus.ic1_req = 1'b0;
    n_checks++;
    if (order.size() != 6) begin
      n_fail++; $display("FAIL cont_count: got %0d acks want 6", order.size());
    end
    n0 = 0; n1 = 0;
    foreach (order[k]) begin
      if (order[k] == 0) n0++; else n1++;
      n_checks++;
      if (order[k] != k % 2) begin
        n_fail++; $display("FAIL cont_order[%0d]: got client %0d want %0d", k, order[k], k % 2);
      end
    end
    n_checks++;
    if (n0 != 3 || n1 != 3) begin
      n_fail++; $display("FAIL cont_share: got %0d/%0d want 3/3", n0, n1);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_wrong_ack();
    bit seen;
    ctrl_en = 1'b0;
    m_wack = 1'b0; m_rack = 1'b0;
    bus.ic0_we = 1'b0; bus.ic0_addr = 22'h000ABC; bus.ic0_req = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.oread_req) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL wa_issue: oread_req never rose"); end
    repeat (2) @(negedge clk);
    m_wack = 1'b1;
    @(negedge clk);
    m_wack = 1'b0;
    n_checks++;
    if (bus.oread_req !== 1'b1 || bus.oc0_ack !== 1'b0) begin
      n_fail++; $display("FAIL wa_ignore: rreq %b ack %b want 1/0", bus.oread_req, bus.oc0_ack);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.oread_req !== 1'b1) begin
      n_fail++; $display("FAIL wa_hold: rreq %b want 1", bus.oread_req);
    end
    m_rdata = 16'h1234; m_rack = 1'b1;
    @(negedge clk);
    m_rack = 1'b0;
    n_checks++;
    if (bus.oc0_ack !== 1'b1 || bus.oc0_rdata !== 16'h1234 || bus.oread_req !== 1'b0) begin
      n_fail++;
      $display("FAIL wa_done: ack %b rdata %h rreq %b want 1 1234 0",
               bus.oc0_ack, bus.oc0_rdata, bus.oread_req);
    end
    bus.ic0_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int  rcycles;
    bit  got;
    bit  ack_seen;
    do_reset();
    n_checks++;
    if (bus.otimeout !== 1'b0) begin n_fail++; $display("FAIL to_pre: otimeout %b want 0", bus.otimeout); end
    bus.ic1_we = 1'b0; bus.ic1_addr = 22'h155555; bus.ic1_req = 1'b1;
    rcycles = 0; got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (bus.oc1_ack) begin
        got = 1'b1;
        n_checks++;
        if (bus.otimeout !== 1'b1 || bus.oc1_rdata !== '0 || bus.oread_req !== 1'b0) begin
          n_fail++;
          $display("FAIL to_abort: timeout %b rdata %h rreq %b want 1 0000 0",
                   bus.otimeout, bus.oc1_rdata, bus.oread_req);
        end
        bus.ic1_req = 1'b0;
      end else if (bus.oread_req) begin
        rcycles++;
      end
    end
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL to_ack: no oc1_ack after timeout"); end
    n_checks++;
    if (rcycles != TO + 1) begin
      n_fail++; $display("FAIL to_len: rreq high %0d cycles want %0d", rcycles, TO + 1);
    end
    // A good transaction afterwards must not clear the sticky flag.
    ctrl_en = 1'b1; ctrl_lat = 2;
    bus.ic0_we = 1'b1; bus.ic0_addr = 22'h002000; bus.ic0_wdata = 16'h0F0F; bus.ic0_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (bus.oc0_ack) begin got = 1'b1; bus.ic0_req = 1'b0; end
    end
    n_checks++;
    if (!got || bus.otimeout !== 1'b1) begin
      n_fail++; $display("FAIL to_sticky: ack %b otimeout %b want 1/1", got, bus.otimeout);
    end
    @(negedge clk);
    ctrl_en = 1'b0; m_wack = 1'b0; m_rack = 1'b0;
    bus.ic0_we = 1'b1; bus.ic0_addr = 22'h003000; bus.ic0_req = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if (bus.owrite_req !== 1'b1) begin
      n_fail++; $display("FAIL rst_wait_pre: wreq %b want 1", bus.owrite_req);
    end
    rst_n = 1'b0;
    ack_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.oc0_ack || bus.oc1_ack) ack_seen = 1'b1;
    end
    n_checks++;
    if ({bus.owrite_req, bus.oread_req, bus.ogrant, bus.otimeout, bus.owrite_address} !== '0) begin
      n_fail++;
      $display("FAIL rst_wait_out: wreq %b rreq %b grant %b timeout %b addr %h want all 0",
               bus.owrite_req, bus.oread_req, bus.ogrant, bus.otimeout, bus.owrite_address);
    end
    bus.ic0_req = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.oc0_ack || bus.oc1_ack || bus.owrite_req) ack_seen = 1'b1;
    end
    n_checks++;
    if (ack_seen) begin n_fail++; $display("FAIL rst_wait_ack: got ack/req after reset want none"); end
  endtask

  task automatic test_random();
    bit [1:0]      mode;
    logic          we [2];
    logic [AW-1:0] a [2];
    logic [DW-1:0] wd [2];
    int            order_exp [2];
    logic [DW-1:0] rd_exp [2];
    int            n_exp, n_got, c;
    logic [DW-1:0] rd;
    do_reset();
    ref_mem.delete();
    ctrl_en = 1'b1;
    for (int it = 0; it < 24; it++) begin
      mode     = 2'($urandom_range(1, 3));
      ctrl_lat = $urandom_range(1, 6);
      for (int k = 0; k < 2; k++) begin
        we[k] = 1'($urandom_range(0, 1));
        a[k]  = AW'($urandom_range(0, 7));
        wd[k] = DW'($urandom);
      end
      if (mode == 2'b11) begin
        order_exp[0] = model_last ? 0 : 1;
        order_exp[1] = 1 - order_exp[0];
        n_exp = 2;
      end else begin
        order_exp[0] = (mode == 2'b01) ? 0 : 1;
        order_exp[1] = 0;
        n_exp = 1;
      end
      model_last = (order_exp[n_exp - 1] == 1);
      for (int k = 0; k < n_exp; k++) begin
        c = order_exp[k];
        if (we[c]) begin
          ref_mem[a[c]] = wd[c];
          rd_exp[k] = '0;
        end else begin
          rd_exp[k] = ref_mem.exists(a[c]) ? ref_mem[a[c]] : rd_default;
        end
      end
      bus.ic0_we = we[0]; bus.ic0_addr = a[0]; bus.ic0_wdata = wd[0];
      bus.ic1_we = we[1]; bus.ic1_addr = a[1]; bus.ic1_wdata = wd[1];
      bus.ic0_req = mode[0]; bus.ic1_req = mode[1];
      n_got = 0;
      for (int cyc = 0; cyc < 100 && n_got < n_exp; cyc++) begin
        @(negedge clk);
        if (bus.oc0_ack || bus.oc1_ack) begin
          c  = bus.oc1_ack ? 1 : 0;
          rd = bus.oc1_ack ? bus.oc1_rdata : bus.oc0_rdata;
          n_checks++;
          if (c != order_exp[n_got] || (bus.oc0_ack && bus.oc1_ack)) begin
            n_fail++;
            $display("FAIL rnd_order it%0d: got client %0d (acks %b%b) want %0d",
                     it, c, bus.oc1_ack, bus.oc0_ack, order_exp[n_got]);
          end
          n_checks++;
          if (rd !== rd_exp[n_got]) begin
            n_fail++; $display("FAIL rnd_rdata it%0d: got %h want %h", it, rd, rd_exp[n_got]);
          end
          if (c == 0) bus.ic0_req = 1'b0; else bus.ic1_req = 1'b0;
          n_got++;
        end
      end
      n_checks++;
      if (n_got != n_exp) begin
        n_fail++; $display("FAIL rnd_done it%0d: got %0d acks want %0d", it, n_got, n_exp);
      end
      bus.ic0_req = 1'b0; bus.ic1_req = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    clear_inputs();
    test_reset();
    test_single_write();
    test_single_read();
    test_contention();
    test_wrong_ack();
    test_timeout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
